// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM bridge.
// Latency constants count clock edges from the request edge to the edge that samples ack/err.
package wb_sram_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_0     = 3'd1,
        RD_1     = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int RD_ACK_LAT  = 3;
    localparam int WR_ACK_LAT  = 4;
    localparam int ERR_ACK_LAT = 1;

    localparam logic [9:0] BASE_TAG_DEFAULT = 10'h200;

endpackage

// File: rtl/wb_sram_if.sv
// Wishbone classic slave-side bundle (signal names seen from the slave).
// wb_err_o exists only when WB_SRAM_ERR_EN is defined.
interface wb_sram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      wb_cyc_i;
    logic                      wb_stb_i;
    logic                      wb_we_i;
    logic [ADDR_WIDTH-1:0]     wb_adr_i;
    logic [DATA_WIDTH-1:0]     wb_dat_i;
    logic [DATA_WIDTH/8-1:0]   wb_sel_i;
    logic                      wb_ack_o;
    logic [DATA_WIDTH-1:0]     wb_dat_o;
`ifdef WB_SRAM_ERR_EN
    logic                      wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_dat_o, wb_err_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_dat_o, wb_err_o
    );
`else
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_dat_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_dat_o
    );
`endif
endinterface

// File: rtl/sram_io_buf.sv
// Tri-state pad for the bidirectional SRAM data bus.
// Latency: combinational; backpressure: none (pure pad logic).
// Drive enable must already be registered so the bus never glitches onto the pins.
module sram_io_buf #(
    parameter int WIDTH = 32
) (
    input  logic             i_drv_en,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat,
    inout  wire  [WIDTH-1:0] io_pad
);

    assign io_pad = i_drv_en ? i_dat : {WIDTH{1'bz}};
    assign o_dat  = io_pad;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave driving an asynchronous SRAM; optional tag check under WB_SRAM_ERR_EN.
// Latency: ack on the 3rd (read) / 4th (write) edge after the request edge, err on the 1st.
// Backpressure: one transfer at a time; requests are only taken in IDLE, ack itself is the throttle.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int         DATA_WIDTH      = 32,
    parameter int         ADDR_WIDTH      = 32,
    parameter int         SRAM_ADDR_WIDTH = 20,
    parameter int         SRAM_DATA_WIDTH = 32,
    parameter logic [9:0] BASE_TAG        = BASE_TAG_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    wb_sram_if.slave                     wb,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

    state_t                         r_state;
    state_t                         w_next;
    logic                           w_req;
    logic                           w_tag_ok;
    logic                           w_ce_n;
    logic                           w_oe_n;
    logic                           w_we_n;
    logic                           w_drv;
    logic                           w_unused;

    logic [SRAM_ADDR_WIDTH-1:0]     r_addr;
    logic [SRAM_DATA_WIDTH/8-1:0]   r_be_n;
    logic [SRAM_DATA_WIDTH-1:0]     r_wdat;
    logic [SRAM_DATA_WIDTH-1:0]     r_rdat;
    logic [SRAM_DATA_WIDTH-1:0]     w_din;
    logic                           r_ce_n;
    logic                           r_oe_n;
    logic                           r_we_n;
    logic                           r_drv;
    logic                           r_ack;

    assign w_req = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef WB_SRAM_ERR_EN
    logic r_err;
    assign w_tag_ok    = (wb.wb_adr_i[31:22] == BASE_TAG);
    assign wb.wb_err_o = r_err;
`else
    assign w_tag_ok = 1'b1;
`endif

    // Parameters that only shape the interface or the optional tag check.
    assign w_unused = (ADDR_WIDTH == 0) ^ (DATA_WIDTH == 0) ^ (BASE_TAG == 10'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_tag_ok)          w_next = DONE;
                    else if (wb.wb_we_i)    w_next = WR_SETUP;
                    else                    w_next = RD_0;
                end
            end
            RD_0:     w_next = RD_1;
            RD_1:     w_next = DONE;
            WR_SETUP: w_next = WR_PULSE;
            WR_PULSE: w_next = WR_HOLD;
            WR_HOLD:  w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        w_ce_n = 1'b1;
        w_oe_n = 1'b1;
        w_we_n = 1'b1;
        w_drv  = 1'b0;
        case (w_next)
            RD_0, RD_1: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                w_ce_n = 1'b0;
                w_drv  = 1'b1;
            end
            WR_PULSE: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
                w_drv  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_be_n  <= '1;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drv   <= 1'b0;
            r_ack   <= 1'b0;
`ifdef WB_SRAM_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_we_n  <= w_we_n;
            r_drv   <= w_drv;
            if (r_state == IDLE && w_req) begin
                r_addr <= wb.wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                r_wdat <= wb.wb_dat_i;
            end
            if (w_ce_n)
                r_be_n <= '1;
            else if (r_state == IDLE)
                r_be_n <= ~wb.wb_sel_i;
            if (r_state == RD_1)
                r_rdat <= w_din;
            // An abandoned cycle still runs the SRAM sequence but earns no ack.
            r_ack <= (w_next == DONE) && (r_state != IDLE) && wb.wb_cyc_i;
`ifdef WB_SRAM_ERR_EN
            r_err <= (w_next == DONE) && (r_state == IDLE);
`endif
        end
    end

    sram_io_buf #(
        .WIDTH (SRAM_DATA_WIDTH)
    ) u_io_buf (
        .i_drv_en (r_drv),
        .i_dat    (r_wdat),
        .o_dat    (w_din),
        .io_pad   (sram_data)
    );

    assign sram_addr   = r_addr;
    assign sram_be_n   = r_be_n;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_rdat;

endmodule
